resp_manager: RTL

//  Transmit-side counterpart of the command-frame assembler: serialises a 32-bit

---
 rtl/resp_manager_pkg.sv | 5 +
 rtl/resp_manager_toggle_edge_detect.sv | 14 +
 rtl/resp_manager.sv | 74 +++++++
 3 files changed

// File: rtl/resp_manager_pkg.sv
// resp_manager_pkg: shared frame default and FSM state encoding for resp_manager
package resp_manager_pkg;
  localparam int FRAME_BYTES_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/resp_manager_toggle_edge_detect.sv
// resp_manager_toggle_edge_detect: toggled=1 while d differs from its last sampled value (clk, reset, en, d -> toggled)
module resp_manager_toggle_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic toggled
);
  logic q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= 1'b0;
    else if (en) q <= d;
  assign toggled = d ^ q;
endmodule

// File: rtl/resp_manager.sv
// resp_manager: serialises resp_frame into toggle-handshaked bytes (frame_valid/frame_ready in, out_byte/byte_strobe/byte_taken link, busy/frame_done status)
module resp_manager
  import resp_manager_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [8*FRAME_BYTES-1:0] resp_frame,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [7:0]               out_byte,
  output logic                     byte_strobe,
  input  logic                     byte_taken,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int W  = 8 * FRAME_BYTES;
  localparam int IW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  state_t state, state_n;
  logic [W-1:0] sr;
  logic [IW-1:0] idx;
  logic ack, accept, last;
  function automatic logic [7:0] head(input logic [W-1:0] x);
    return MSB_FIRST ? x[W-1 -: 8] : x[7:0];
  endfunction
  function automatic logic [W-1:0] shift(input logic [W-1:0] x);
    return MSB_FIRST ? x << 8 : x >> 8;
  endfunction
  resp_manager_toggle_edge_detect ack_det (
    .clk(clk),
    .reset(reset),
    .en(en && state != LOAD),
    .d(byte_taken),
    .toggled(ack)
  );
  assign frame_ready = state == IDLE;
  assign busy        = state != IDLE;
  assign frame_done  = state == DONE && en;
  assign accept      = frame_valid && frame_ready && en;
  assign last        = idx == IW'(FRAME_BYTES - 1);
  always_comb begin
    state_n = state;
    if (en)
      state_n = state == IDLE ? (frame_valid ? LOAD : IDLE) :
                state == LOAD ? WAIT :
                state == WAIT ? (ack && last ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr          <= '0;
      idx         <= '0;
      out_byte    <= 8'h00;
      byte_strobe <= 1'b0;
    end else if (en) begin
      if (accept) begin
        sr  <= resp_frame;
        idx <= '0;
      end else if (state == LOAD) begin
        out_byte    <= head(sr);
        byte_strobe <= ~byte_strobe;
      end else if (state == WAIT && ack && !last) begin
        sr          <= shift(sr);
        idx         <= idx + 1'b1;
        out_byte    <= head(shift(sr));
        byte_strobe <= ~byte_strobe;
      end
    end
endmodule
